// File: rtl/vga_ctrl.sv
// ============================================================================
// Module   : vga_ctrl
// Brief    : 640x480@60 VGA timing generator; requests pixels one clock early
//            and gates the returned RGB565 data. Optional VGA_FRAME_CNT_EN
//            adds an 8-bit frame counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_END   = 10'(H_SYNC);
  localparam logic [9:0] VS_END   = 10'(V_SYNC);
  localparam logic [9:0] HA       = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HA_END   = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] HREQ_BEG = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] HREQ_END = 10'(H_SYNC + H_BACK + H_VALID - 2);
  localparam logic [9:0] VA       = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VA_END   = 10'(V_SYNC + V_BACK + V_VALID);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       frame_last;
  logic       v_act;
  logic       req;

  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      frame_cnt <= '0;
    end else if (frame_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  logic unused_frame_last;
  assign unused_frame_last = frame_last;
`endif

  // Requests lead rgb_valid by one clock to cover vga_pic's registered output.
  always_comb begin
    v_act     = (v_cnt >= VA) && (v_cnt < VA_END);
    req       = v_act && (h_cnt >= HREQ_BEG) && (h_cnt <= HREQ_END);
    pix_x     = req ? (h_cnt - HREQ_BEG) : 10'h3FF;
    pix_y     = req ? (v_cnt - VA) : 10'h3FF;
    rgb_valid = v_act && (h_cnt >= HA) && (h_cnt < HA_END);
    rgb       = rgb_valid ? pix_data : 16'h0000;
    hsync     = (h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync     = (v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_ctrl.sv
// ============================================================================
// Module   : tb_vga_ctrl
// Brief    : Directed bench for vga_ctrl: default-size instance plus a small
//            active-high-sync instance for frame-level and frame_cnt checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_ctrl;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  int          tcyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          rst_done = 1'b0;
  bit          s_done = 1'b0;
  bit          f_done = 1'b0;
  bit          first_pass = 1'b1;
  int          rv35 = 0;
  int          hslow0 = 0;

  logic [15:0] pix_data, s_pix_data;
  logic [9:0]  pix_x, pix_y, s_pix_x, s_pix_y;
  logic        hsync, vsync, rgb_valid, s_hsync, s_vsync, s_rgb_valid;
  logic [15:0] rgb, s_rgb;
  logic [7:0]  frame_cnt, s_frame_cnt;

  always #20 vga_clk = ~vga_clk;

  vga_ctrl dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // H_TOTAL 17 (HA 7), V_TOTAL 9 (VA 4): 153 clocks per frame
  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1), .SYNC_POL(1'b1)
  ) dut_s (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(s_pix_data),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .hsync(s_hsync), .vsync(s_vsync),
    .rgb_valid(s_rgb_valid), .rgb(s_rgb)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(s_frame_cnt)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign frame_cnt   = 8'd0;
  assign s_frame_cnt = 8'd0;
`endif

  // vga_pic model: registered {row[5:0], column}
  always @(posedge vga_clk) begin
    pix_data   <= {pix_y[5:0], pix_x};
    s_pix_data <= {s_pix_y[5:0], s_pix_x};
  end

  // Bench timebase: equals the clock index within the frame since reset.
  always @(posedge vga_clk) tcyc <= sys_rst ? 0 : tcyc + 1;

  always @(negedge vga_clk) begin
    if (rst_done && first_pass && !sys_rst) begin
      if (tcyc >= 28000 && tcyc < 28800 && rgb_valid) rv35++;
      if (tcyc < 800 && hsync == 1'b0) hslow0++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (tcyc=%0d)", name, act, exp, tcyc);
  endtask

  task automatic advance_to(input int t);
    while (tcyc < t) @(negedge vga_clk);
  endtask

  typedef struct {
    int          t;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        rv;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } vec_t;

  vec_t vecs[14];

  // Main sequence on the default-size instance
  initial begin
    vecs[0]  = '{0,     10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{95,    10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{96,    10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1599,  10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1600,  10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[5]  = '{27343, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[6]  = '{27400, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[7]  = '{28143, 10'd0,   10'd0,   1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[8]  = '{28144, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[9]  = '{28145, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 16'h0001};
    vecs[10] = '{28782, 10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 16'h027E};
    vecs[11] = '{28783, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 16'h027F};
    vecs[12] = '{28784, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[13] = '{28945, 10'd2,   10'd1,   1'b1, 1'b1, 1'b1, 16'h0401};

    sys_rst = 1'b1;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst  = 1'b0;
    rst_done = 1'b1;

    for (int i = 0; i < 14; i++) begin
      advance_to(vecs[i].t);
      chk($sformatf("pix_x@%0d", vecs[i].t), 32'(pix_x), 32'(vecs[i].px));
      chk($sformatf("pix_y@%0d", vecs[i].t), 32'(pix_y), 32'(vecs[i].py));
      chk($sformatf("rgb_valid@%0d", vecs[i].t), 32'(rgb_valid), 32'(vecs[i].rv));
      chk($sformatf("hsync@%0d", vecs[i].t), 32'(hsync), 32'(vecs[i].hs));
      chk($sformatf("vsync@%0d", vecs[i].t), 32'(vsync), 32'(vecs[i].vs));
      chk($sformatf("rgb@%0d", vecs[i].t), 32'(rgb), 32'(vecs[i].rgb));
    end

    advance_to(28801);
    chk("rgb_valid_count_line35", 32'(rv35), 32'd640);
    chk("hsync_low_count_line0", 32'(hslow0), 32'd96);

    // Mid-frame reset at line 60, column 400
    advance_to(48400);
    sys_rst = 1'b1;
    first_pass = 1'b0;
    @(negedge vga_clk);
    sys_rst = 1'b0;
    chk("mrst_hsync", 32'(hsync), 32'd0);
    chk("mrst_vsync", 32'(vsync), 32'd0);
    chk("mrst_rgb_valid", 32'(rgb_valid), 32'd0);
    chk("mrst_rgb", 32'(rgb), 32'd0);
    chk("mrst_pix_x", 32'(pix_x), 32'h3FF);
    chk("mrst_pix_y", 32'(pix_y), 32'h3FF);
    chk("mrst_s_hsync", 32'(s_hsync), 32'd1);
    advance_to(96);
    chk("mrst_hsync_rise", 32'(hsync), 32'd1);
    advance_to(1600);
    chk("mrst_vsync_rise", 32'(vsync), 32'd1);
    advance_to(28144);
    chk("mrst_rgb_valid_l35", 32'(rgb_valid), 32'd1);
    chk("mrst_pix_x_l35", 32'(pix_x), 32'd1);

    for (int i = 0; i < 2000 && !(s_done && f_done); i++) @(negedge vga_clk);
    if (!(s_done && f_done)) chk("side_process_timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Small instance: active-high sync, last pixel of last row, frame period
  initial begin
    int t1, t2, n;
    wait (rst_done);
    chk("s_reset_vsync", 32'(s_vsync), 32'd1);
    advance_to(3);
    chk("s_hsync_active", 32'(s_hsync), 32'd1);
    advance_to(4);
    chk("s_hsync_inactive", 32'(s_hsync), 32'd0);
    advance_to(132);
    chk("s_last_req_x", 32'(s_pix_x), 32'd7);
    chk("s_last_req_y", 32'(s_pix_y), 32'd3);
    chk("s_rgb_prev", 32'(s_rgb), 32'h0C06);
    advance_to(133);
    chk("s_after_req_x", 32'(s_pix_x), 32'h3FF);
    chk("s_last_rgb", 32'(s_rgb), 32'h0C07);
    chk("s_last_rv", 32'(s_rgb_valid), 32'd1);
    advance_to(134);
    chk("s_rv_fall", 32'(s_rgb_valid), 32'd0);
    chk("s_rgb_gated", 32'(s_rgb), 32'd0);

    t1 = -1; t2 = -1; n = 0;
    while (s_vsync == 1'b1 && n < 1000) begin @(negedge vga_clk); n++; end
    while (s_vsync == 1'b0 && n < 1000) begin @(negedge vga_clk); n++; end
    t1 = n;
    while (s_vsync == 1'b1 && n < 1000) begin @(negedge vga_clk); n++; end
    while (s_vsync == 1'b0 && n < 1000) begin @(negedge vga_clk); n++; end
    t2 = n;
    chk("s_frame_period", 32'(t2 - t1), 32'd153);
    s_done = 1'b1;
  end

  // Frame counter: steps on the last clock of each 153-clock frame
  initial begin
    wait (rst_done);
`ifdef VGA_FRAME_CNT_EN
    chk("fc_reset", 32'(s_frame_cnt), 32'd0);
    for (int k = 0; k < 257; k++) begin
      advance_to(153 * k + 152);
      chk($sformatf("fc_hold_%0d", k), 32'(s_frame_cnt), 32'(k % 256));
      advance_to(153 * k + 153);
      chk($sformatf("fc_step_%0d", k), 32'(s_frame_cnt), 32'((k + 1) % 256));
    end
    chk("fc_default_inst", 32'(frame_cnt), 32'd0);
`endif
    f_done = 1'b1;
  end

endmodule

`default_nettype wire
